// File: rtl/macc_txn_collector.sv
// Control and collection stage for the hls_macc core: launches one core run per
// command, captures its strobed outputs into a record FIFO and keeps running stats.
module macc_txn_collector #(
    parameter int DEPTH   = 4,
    parameter int ACC_W   = 48,
    parameter int TIMEOUT = 15
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic             macc_start,
    input  logic             macc_done,
    input  logic [31:0]      macc_out13,
    input  logic             macc_out13_vld,
    input  logic [31:0]      macc_out30,
    input  logic             macc_out30_vld,
    input  logic [31:0]      macc_out31,
    input  logic             macc_out31_vld,
    input  logic [31:0]      macc_ret,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_out13,
    output logic [31:0]      res_out30,
    output logic [31:0]      res_out31,
    output logic [31:0]      res_ret,
    output logic             res_out30_seen,
    output logic [ACC_W-1:0] acc,
    output logic [15:0]      txn_cnt,
    output logic             err_timeout,
    input  logic             clear
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = PW + 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PUSH
    } state_t;

    typedef struct packed {
        logic [31:0] out13;
        logic [31:0] out30;
        logic [31:0] out31;
        logic [31:0] ret;
        logic        out30_seen;
    } rec_t;

    state_t          state_q, state_d;
    rec_t            cap_q;
    logic [WD_W-1:0] wd_cnt;
    logic            accept, push, pop, timeout;

    logic [PW-1:0]   wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0]   count;
    rec_t            mem [DEPTH];
    rec_t            head_q;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples
            // pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a branch that
        // forgot one would otherwise infer a latch.
        state_d    = state_q;
        cmd_ready  = 1'b0;
        macc_start = 1'b0;
        accept     = 1'b0;
        push       = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = (count < CW'(DEPTH));
                if (cmd_valid && cmd_ready) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                macc_start = 1'b1;
                if (macc_done) begin
                    state_d = S_PUSH;
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_PUSH: begin
                push    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------ capture + watchdog
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cap_q  <= '0;
            wd_cnt <= '0;
        end else if (accept) begin
            cap_q  <= '0;
            wd_cnt <= '0;
        end else if (state_q == S_RUN) begin
            if (macc_out13_vld) cap_q.out13 <= macc_out13;
            if (macc_out30_vld) begin
                cap_q.out30      <= macc_out30;
                cap_q.out30_seen <= 1'b1;
            end
            // ap_return is only qualified by the out31 strobe on this core.
            if (macc_out31_vld) begin
                cap_q.out31 <= macc_out31;
                cap_q.ret   <= macc_ret;
            end
            if (!macc_done) wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // ---------------------------------------------------------------- stats
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc         <= '0;
            txn_cnt     <= '0;
            err_timeout <= 1'b0;
        end else if (clear) begin
            acc         <= '0;
            txn_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (push) begin
                acc     <= acc + ACC_W'(signed'(cap_q.ret));
                txn_cnt <= txn_cnt + 16'd1;
            end
            if (timeout) err_timeout <= 1'b1;
        end
    end

    // ----------------------------------------------------------------- FIFO
    assign res_valid = (count != '0);
    assign pop       = res_valid && res_ready;
    assign rd_next   = rd_ptr + PW'(1);

    // NOTE: the storage array has no reset; nothing reads a slot before it is
    // written, and the visible head record lives in a separately reset register.
    always_ff @(posedge ap_clk) begin
        if (push) mem[wr_ptr] <= cap_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_next;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Head follows the next stored record, or the incoming one when it
            // becomes the only entry; an emptied FIFO keeps showing the last head.
            if (pop) begin
                if (count > CW'(1)) head_q <= mem[rd_next];
                else if (push)      head_q <= cap_q;
            end else if (push && count == '0) begin
                head_q <= cap_q;
            end
        end
    end

    assign res_out13      = head_q.out13;
    assign res_out30      = head_q.out30;
    assign res_out31      = head_q.out31;
    assign res_ret        = head_q.ret;
    assign res_out30_seen = head_q.out30_seen;

endmodule

// File: tb/tb_macc_txn_collector.sv
// Randomized bench for macc_txn_collector: an emulated core drives strobes and a
// queue-based record model tracks FIFO contents, accumulator and counters.
module tb_macc_txn_collector;

    localparam int DEPTH   = 4;
    localparam int ACC_W   = 48;
    localparam int TIMEOUT = 15;

    logic             ap_clk, ap_rst_n;
    logic             cmd_valid, cmd_ready, macc_start, macc_done;
    logic [31:0]      macc_out13, macc_out30, macc_out31, macc_ret;
    logic             macc_out13_vld, macc_out30_vld, macc_out31_vld;
    logic             res_valid, res_ready;
    logic [31:0]      res_out13, res_out30, res_out31, res_ret;
    logic             res_out30_seen;
    logic [ACC_W-1:0] acc;
    logic [15:0]      txn_cnt;
    logic             err_timeout, clear;

    macc_txn_collector #(.DEPTH(DEPTH), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .macc_start(macc_start), .macc_done(macc_done),
        .macc_out13(macc_out13), .macc_out13_vld(macc_out13_vld),
        .macc_out30(macc_out30), .macc_out30_vld(macc_out30_vld),
        .macc_out31(macc_out31), .macc_out31_vld(macc_out31_vld),
        .macc_ret(macc_ret),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_out13(res_out13), .res_out30(res_out30), .res_out31(res_out31),
        .res_ret(res_ret), .res_out30_seen(res_out30_seen),
        .acc(acc), .txn_cnt(txn_cnt), .err_timeout(err_timeout), .clear(clear)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    typedef struct {
        logic [31:0] out13;
        logic [31:0] out30;
        logic [31:0] out31;
        logic [31:0] ret;
        logic        seen;
    } rec_t;

    int               checks   = 0;
    int               failures = 0;
    int               pop_pct  = 0;
    rec_t             exp_q[$];
    rec_t             last_rec;
    rec_t             cur;
    logic [ACC_W-1:0] acc_m;
    logic [15:0]      txn_m;
    logic             err_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_rec = '{default: '0};
        acc_m = '0;
        txn_m = '0;
        err_m = 1'b0;
    endtask

    task automatic noise();
        macc_out13 = $urandom; macc_out30 = $urandom;
        macc_out31 = $urandom; macc_ret   = $urandom;
        macc_out13_vld = 1'($urandom_range(1));
        macc_out30_vld = 1'($urandom_range(1));
        macc_out31_vld = 1'($urandom_range(1));
        macc_done      = 1'($urandom_range(1));
    endtask

    task automatic new_rec(input int seen_pct);
        cur.out13 = $urandom; cur.out31 = $urandom; cur.ret = $urandom;
        cur.seen  = ($urandom_range(99) < seen_pct);
        cur.out30 = cur.seen ? 32'($urandom) : 32'd0;
    endtask

    // One clock: compare outputs with the model, advance one edge, update the model.
    task automatic tick(input bit push_now, input bit timeout_now);
        bit   do_pop, clr;
        rec_t h;
        res_ready = ($urandom_range(99) < pop_pct);
        check("res_valid", res_valid, exp_q.size() > 0);
        h = (exp_q.size() > 0) ? exp_q[0] : last_rec;
        check("res_out13", res_out13, h.out13);
        check("res_out30", res_out30, h.out30);
        check("res_out31", res_out31, h.out31);
        check("res_ret", res_ret, h.ret);
        check("res_out30_seen", res_out30_seen, h.seen);
        check("acc", acc, acc_m);
        check("txn_cnt", txn_cnt, txn_m);
        check("err_timeout", err_timeout, err_m);
        do_pop = res_ready && (exp_q.size() > 0);
        clr    = clear;
        @(posedge ap_clk);
        #1;
        if (do_pop) last_rec = exp_q.pop_front();
        if (push_now) exp_q.push_back(cur);
        if (clr) begin
            acc_m = '0; txn_m = '0; err_m = 1'b0;
        end else begin
            if (push_now) begin
                acc_m = acc_m + ACC_W'($signed(cur.ret));
                txn_m = txn_m + 16'd1;
            end
            if (timeout_now) err_m = 1'b1;
        end
    endtask

    // Issue one command; lat = RUN cycles until done (0 = core never finishes).
    task automatic run_txn(input int lat, input bit clr_push);
        int n = 0;
        int k13, k30, k31;
        while (!cmd_ready && n < 64) begin
            noise(); tick(0, 0); n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        noise(); cmd_valid = 1'b1;
        tick(0, 0);
        cmd_valid = 1'b0;
        if (lat == 0) begin
            for (int c = 1; c <= TIMEOUT; c++) begin
                check("start_in_run", macc_start, 1);
                noise(); macc_done = 1'b0;
                tick(0, c == TIMEOUT);
            end
            check("start_after_timeout", macc_start, 0);
            return;
        end
        k13 = $urandom_range(lat, 1);
        k30 = $urandom_range(lat, 1);
        k31 = $urandom_range(lat, 1);
        for (int c = 1; c <= lat; c++) begin
            check("start_in_run", macc_start, 1);
            macc_out13_vld = (c == k13);
            macc_out13     = (c == k13) ? cur.out13 : 32'($urandom);
            macc_out30_vld = cur.seen && (c == k30);
            macc_out30     = macc_out30_vld ? cur.out30 : 32'($urandom);
            macc_out31_vld = (c == k31);
            macc_out31     = (c == k31) ? cur.out31 : 32'($urandom);
            macc_ret       = (c == k31) ? cur.ret : 32'($urandom);
            macc_done      = (c == lat);
            tick(0, 0);
        end
        noise();
        check("start_in_push", macc_start, 0);
        clear = clr_push;
        tick(1, 0);
        clear = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, macc_start, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_fields"}, {res_out13, res_out30}, 0);
        check({tag, "_res_fields2"}, {res_out31, res_ret}, 0);
        check({tag, "_seen"}, res_out30_seen, 0);
        check({tag, "_acc"}, acc, 0);
        check({tag, "_txn"}, txn_cnt, 0);
        check({tag, "_err"}, err_timeout, 0);
    endtask

    initial begin
        ap_rst_n = 1'b0;
        cmd_valid = 1'b0; res_ready = 1'b0; clear = 1'b0;
        macc_done = 1'b0; macc_out13_vld = 1'b0; macc_out30_vld = 1'b0; macc_out31_vld = 1'b0;
        macc_out13 = '0; macc_out30 = '0; macc_out31 = '0; macc_ret = '0;
        cur = '{default: '0};
        model_reset();
        repeat (3) @(posedge ap_clk);
        #1;
        check_all_zero("reset");
        ap_rst_n = 1'b1;

        // Equal path: start held for two cycles, result visible four cycles after accept.
        cur = '{out13: 32'd15, out30: 32'd0, out31: 32'd15, ret: 32'd30, seen: 1'b0};
        run_txn(2, 0);
        check("eq_res_valid", res_valid, 1);
        check("eq_res_ret", res_ret, 30);
        check("eq_res_out13", res_out13, 15);
        check("eq_acc", acc, 30);
        check("eq_txn", txn_cnt, 1);
        pop_pct = 100;
        tick(0, 0);

        // Compute path with an out30 strobe.
        pop_pct = 0;
        new_rec(100);
        run_txn(3, 0);
        check("cp_res_valid", res_valid, 1);
        check("cp_seen", res_out30_seen, 1);
        pop_pct = 100;
        tick(0, 0);

        // Fill and backpressure.
        pop_pct = 0;
        for (int i = 0; i < DEPTH; i++) begin
            new_rec(50);
            run_txn($urandom_range(4, 1), 0);
        end
        for (int i = 0; i < 3; i++) begin
            check("full_cmd_ready", cmd_ready, 0);
            noise(); tick(0, 0);
        end
        pop_pct = 100;
        tick(0, 0);
        pop_pct = 0;
        new_rec(50);
        run_txn(2, 0);
        pop_pct = 100;
        repeat (DEPTH + 2) tick(0, 0);

        // Watchdog abort.
        pop_pct = 0;
        run_txn(0, 0);
        check("to_err", err_timeout, 1);
        check("to_txn", txn_cnt, txn_m);
        check("to_res_valid", res_valid, 0);
        check("to_cmd_ready", cmd_ready, 1);
        tick(0, 0);

        // Sign extension and wrap, then clear colliding with a push.
        clear = 1'b1;
        tick(0, 0);
        clear = 1'b0;
        cur = '{out13: 32'd1, out30: 32'd0, out31: 32'd2, ret: 32'hFFFF_FFFF, seen: 1'b0};
        run_txn(2, 0);
        check("acc_minus_one", acc, 48'hFFFF_FFFF_FFFF);
        new_rec(50);
        run_txn(2, 1);
        check("clr_push_acc", acc, 0);
        check("clr_push_txn", txn_cnt, 0);
        check("clr_push_res_valid", res_valid, 1);

        // Randomized traffic with variable core latency, backpressure and aborts.
        for (int i = 0; i < 60; i++) begin
            pop_pct = $urandom_range(100);
            new_rec(50);
            run_txn(($urandom_range(9) == 0) ? 0 : int'($urandom_range(5, 1)),
                    $urandom_range(9) == 0);
        end
        pop_pct = 100;
        repeat (DEPTH + 2) tick(0, 0);

        // Reset in the middle of a run drops the transaction.
        pop_pct = 0;
        macc_done = 1'b0; macc_out13_vld = 1'b0; macc_out30_vld = 1'b0; macc_out31_vld = 1'b0;
        cmd_valid = 1'b1;
        tick(0, 0);
        cmd_valid = 1'b0;
        tick(0, 0);
        check("pre_rst_start", macc_start, 1);
        #2 ap_rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        model_reset();
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        new_rec(100);
        run_txn(3, 0);
        check("post_rst_txn", txn_cnt, 1);
        pop_pct = 100;
        repeat (DEPTH + 2) tick(0, 0);
        check("final_empty", res_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
